// File: rtl/hazard_mcycle_ctrl.sv
// Pipeline sequencing controller for a 5-stage (F/D/E/M/W) core.
// Produces the E-stage operand forwarding selects, load-use stalls and
// branch flushes. A small handshake FSM holds the pipe while the multi-cycle
// MUL/DIV unit works on the E-stage instruction, and abandons the operation
// after TIMEOUT wait cycles. A saturating counter tracks fetch-stall cycles.
module hazard_mcycle_ctrl #(
  parameter int unsigned TIMEOUT = 64,  // max WAIT cycles, must be >= 2
  parameter int unsigned CNT_W   = 16   // width of the stall-cycle counter
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             BranchTakenE,
  input  logic             MOpE,
  input  logic             MDone,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MStart,
  output logic             MErr,
  output logic [CNT_W-1:0] StallCnt
);

  // Timeout counter only has to reach TIMEOUT-1.
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait
  } state_e;

  // r15 is the PC and is never forwarded from the pipeline.
  localparam logic [3:0] RegPc = 4'd15;

  state_e           r_state;
  state_e           w_state_d;
  logic [TW-1:0]    r_tcnt;
  logic [TW-1:0]    w_tcnt_d;
  logic             r_merr;
  logic             w_merr_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_ldr_stall;
  logic             w_mbusy;
  logic             w_mstart;
  logic             w_stall_fd;
  logic             w_flush_e;

  // Forward select for one E-stage source: M result has priority over W.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic rw_m,
                                         input logic [3:0] wa_m, input logic rw_w,
                                         input logic [3:0] wa_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (rw_m && (wa_m == ra) && (wa_m != RegPc)) begin
      sel = 2'b10;
    end else if (rw_w && (wa_w == ra) && (wa_w != RegPc)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Operand forwarding selects for both E-stage sources.
  always_comb begin
    w_fwd_a = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    w_fwd_b = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
  end

  // Load-use hazard: D reads the register a load in E is about to write.
  always_comb begin
    w_ldr_stall = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
  end

  // Multi-cycle handshake: next state, timeout count, busy and start pulse.
  always_comb begin
    w_state_d = r_state;
    w_tcnt_d  = r_tcnt;
    w_merr_d  = r_merr;
    w_mbusy   = 1'b0;
    w_mstart  = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Hold the pipe from the very cycle the op reaches E.
        w_mbusy = MOpE;
        if (MOpE) begin
          w_state_d = StLaunch;
        end
      end
      StLaunch: begin
        w_mbusy   = 1'b1;
        w_mstart  = 1'b1;
        w_tcnt_d  = '0;
        w_state_d = StWait;
      end
      StWait: begin
        if (MDone) begin
          // Result valid: E advances on this same edge.
          w_state_d = StIdle;
        end else begin
          w_mbusy = 1'b1;
          if (r_tcnt == TLast) begin
            w_merr_d  = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_tcnt_d = r_tcnt + TW'(1);
          end
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Stall and flush combination; a taken branch overrides the F/D hold.
  always_comb begin
    w_stall_fd = (w_ldr_stall | w_mbusy) & ~BranchTakenE;
    w_flush_e  = BranchTakenE | (w_ldr_stall & ~w_mbusy);
  end

  // Saturating count of cycles with the fetch stage held.
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_stall_fd && (r_cnt != CntMax)) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
  end

  // State registers; reset aborts any multi-cycle op immediately.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= StIdle;
      r_tcnt  <= '0;
      r_merr  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_tcnt  <= w_tcnt_d;
      r_merr  <= w_merr_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Every output is forced low while reset is held, including the
  // combinational ones.
  always_comb begin
    ForwardAE = Reset_n ? w_fwd_a : 2'b00;
    ForwardBE = Reset_n ? w_fwd_b : 2'b00;
    StallF    = Reset_n & w_stall_fd;
    StallD    = Reset_n & w_stall_fd;
    StallE    = Reset_n & w_mbusy;
    FlushD    = Reset_n & BranchTakenE;
    FlushE    = Reset_n & w_flush_e;
    FlushM    = Reset_n & w_mbusy;
    MStart    = Reset_n & w_mstart;
    MErr      = Reset_n & r_merr;
    StallCnt  = Reset_n ? r_cnt : '0;
  end

endmodule

// File: tb/tb_hazard_mcycle_ctrl.sv
// Self-checking bench for hazard_mcycle_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model every cycle.
module tb_hazard_mcycle_ctrl;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 6;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             Reset_n;
  logic [3:0]       RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic             RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic             BranchTakenE, MOpE, MDone;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic             MStart, MErr;
  logic [CNT_W-1:0] StallCnt;

  hazard_mcycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
    .MOpE(MOpE), .MDone(MDone),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MStart(MStart), .MErr(MErr), .StallCnt(StallCnt)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model. The multi-cycle op is tracked as a phase:
  //   busy_op   : an op has been accepted and not yet finished
  //   launched  : start pulse already issued
  //   waited    : number of wait cycles already spent after the start pulse
  bit m_busy_op, m_launched, m_merr;
  int m_waited;
  int m_cnt;

  // Expected values for the current cycle.
  int e_fa, e_fb, e_sfd, e_se, e_fd, e_fe, e_fm, e_ms;
  bit e_ldr, e_busy;

  function automatic int fwd(input logic [3:0] ra);
    if (RegWriteM && WA3M == ra && WA3M != 4'd15) return 2;
    if (RegWriteW && WA3W == ra && WA3W != 4'd15) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy_op  = 0;
    m_launched = 0;
    m_waited   = 0;
    m_merr     = 0;
    m_cnt      = 0;
  endtask

  task automatic compute_expect();
    e_fa  = fwd(RA1E);
    e_fb  = fwd(RA2E);
    e_ldr = MemtoRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D);
    if (!m_busy_op)      e_busy = MOpE;
    else if (!m_launched) e_busy = 1;
    else                 e_busy = !MDone;
    e_sfd = (e_ldr || e_busy) && !BranchTakenE;
    e_se  = e_busy;
    e_fm  = e_busy;
    e_fd  = BranchTakenE;
    e_fe  = BranchTakenE || (e_ldr && !e_busy);
    e_ms  = m_busy_op && !m_launched;
  endtask

  // Advance the model across one rising edge using the inputs held now.
  task automatic model_step();
    if (e_sfd && m_cnt < CNT_MAX) m_cnt++;
    if (!m_busy_op) begin
      if (MOpE) begin
        m_busy_op  = 1;
        m_launched = 0;
      end
    end else if (!m_launched) begin
      m_launched = 1;
      m_waited   = 0;
    end else if (MDone) begin
      m_busy_op = 0;
    end else begin
      m_waited++;
      if (m_waited == TIMEOUT) begin
        m_merr    = 1;
        m_busy_op = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    compute_expect();
    chk("ForwardAE", 32'(ForwardAE), 32'(e_fa));
    chk("ForwardBE", 32'(ForwardBE), 32'(e_fb));
    chk("StallF",    32'(StallF),    32'(e_sfd));
    chk("StallD",    32'(StallD),    32'(e_sfd));
    chk("StallE",    32'(StallE),    32'(e_se));
    chk("FlushD",    32'(FlushD),    32'(e_fd));
    chk("FlushE",    32'(FlushE),    32'(e_fe));
    chk("FlushM",    32'(FlushM),    32'(e_fm));
    chk("MStart",    32'(MStart),    32'(e_ms));
    chk("MErr",      32'(MErr),      32'(m_merr));
    chk("StallCnt",  32'(StallCnt),  32'(m_cnt));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_fwd"},  32'({ForwardAE, ForwardBE}), 32'd0);
    chk({tag, "_ctl"},  32'({StallF, StallD, StallE, FlushD, FlushE, FlushM, MStart, MErr}),
        32'd0);
    chk({tag, "_cnt"},  32'(StallCnt), 32'd0);
  endtask

  // Check this cycle, then move to just after the next rising edge.
  task automatic step();
    #2;
    check_all();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    {RA1D, RA2D, RA1E, RA2E} = '0;
    WA3E = 4'd9; WA3M = 4'd9; WA3W = 4'd9;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
    {BranchTakenE, MOpE, MDone} = '0;
  endtask

  function automatic logic [3:0] rreg();
    logic [3:0] r;
    r = 4'($urandom_range(0, 4));
    if (r == 4'd4) r = 4'd15;
    return r;
  endfunction

  initial begin
    clear_inputs();
    Reset_n = 1'b0;
    // Drive activity that would light up outputs if reset did not gate them.
    RegWriteM = 1; WA3M = 4'd1; RA1E = 4'd1; BranchTakenE = 1; MOpE = 1;
    #3;
    check_zero("reset_hold");
    model_reset();
    @(posedge CLK); #1;
    clear_inputs();
    Reset_n = 1'b1;
    step();

    // Forwarding: r1 in M, r1 only in W, r15 in M.
    RA1E = 4'd1; RA2E = 4'd1; RegWriteM = 1; WA3M = 4'd1; RegWriteW = 1; WA3W = 4'd1;
    step();
    RegWriteM = 0;
    step();
    RegWriteM = 1; WA3M = 4'd15; RegWriteW = 0; RA1E = 4'd15;
    step();
    clear_inputs();

    // Load-use: LDR r2 in E, D reads r2; then it forwards from W.
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd2; RA1D = 4'd2;
    step();
    clear_inputs();
    RA1E = 4'd2; RegWriteW = 1; WA3W = 4'd2;
    step();
    clear_inputs();

    // Branch taken while a load-use hazard is present.
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd3; RA2D = 4'd3; BranchTakenE = 1;
    step();
    clear_inputs();

    // Multi-cycle op completing with MDone 5 cycles after MStart.
    MOpE = 1;
    step();
    step();                       // start pulse
    for (int i = 0; i < 4; i++) step();
    MDone = 1;
    step();
    clear_inputs();
    step();

    // Multi-cycle op that never completes: times out and sets MErr.
    MOpE = 1;
    step();
    MOpE = 0;
    for (int i = 0; i < TIMEOUT + 4; i++) step();

    // Reset in the middle of WAIT: outputs drop without a clock edge.
    MOpE = 1;
    step();
    MOpE = 0;
    step();
    step();
    #2;
    Reset_n = 1'b0;
    #1;
    check_zero("reset_async");
    model_reset();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    Reset_n = 1'b1;
    MDone = 1;                    // late completion must be ignored
    step();
    MDone = 0;
    for (int i = 0; i < 3; i++) step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      RA1D = rreg(); RA2D = rreg(); RA1E = rreg(); RA2E = rreg();
      WA3E = rreg(); WA3M = rreg(); WA3W = rreg();
      RegWriteE    = 1'($urandom_range(0, 1));
      RegWriteM    = 1'($urandom_range(0, 1));
      RegWriteW    = 1'($urandom_range(0, 1));
      MemtoRegE    = ($urandom_range(0, 2) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      MOpE         = ($urandom_range(0, 7) == 0);
      MDone        = ($urandom_range(0, 5) == 0);
      step();
    end

    // Sustained load-use stall drives StallCnt into saturation.
    clear_inputs();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd4; RA1D = 4'd4;
    for (int i = 0; i < CNT_MAX + 10; i++) step();
    clear_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
